// File: rtl/crc_byte_sequencer_pkg.sv
// Shared encodings for the CRC byte sequencer: FSM state codes and bit-walk bounds.
// Also imported by the register map, so the codes must stay stable.
package crc_byte_sequencer_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INIT      = 3'd1;
  localparam logic [2:0] S_WAIT_BYTE = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  // Bits of each byte are presented MSB index first; crcN handles reflection.
  localparam logic [2:0] BIT_FIRST = 3'd7;
  localparam logic [2:0] BIT_LAST  = 3'd0;

  function automatic logic state_is_busy(input logic [2:0] st);
    return (st == S_INIT) || (st == S_WAIT_BYTE) || (st == S_SHIFT);
  endfunction

endpackage

// File: rtl/crc_byte_sequencer.sv
// Byte-stream front end for a bit-serial CRC engine: one accepted byte becomes 8 shift cycles.
// All outputs registered from next state, except in_ready which is decoded from current state.
module crc_byte_sequencer
  import crc_byte_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             crc_initialize,
  output logic             crc_shift,
  output logic [7:0]       crc_data,
  output logic [2:0]       crc_bit_index,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_q;
  logic             shift_q;
  logic             rv_q;
  logic             busy_q;
  logic             ready_w;
  logic             accept_w;

  // A byte can be taken while idle-waiting, or on the final bit of a non-last byte
  // so a continuous stream runs at exactly 8 cycles per byte.
  always_comb begin
    ready_w = 1'b0;
    if (!rst && !start) begin
      case (state_q)
        S_WAIT_BYTE: ready_w = 1'b1;
        S_SHIFT:     ready_w = (bit_idx_q == BIT_LAST) && !last_q;
        default:     ready_w = 1'b0;
      endcase
    end
  end

  assign accept_w = in_valid && ready_w;

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    last_d    = last_q;
    cnt_d     = cnt_q;

    if (start) begin
      state_d = S_INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_INIT: state_d = S_WAIT_BYTE;
        S_WAIT_BYTE: begin
          if (accept_w) begin
            state_d = S_SHIFT;
          end else if (flush) begin
            state_d = S_DONE;
          end
        end
        S_SHIFT: begin
          if (bit_idx_q != BIT_LAST) begin
            bit_idx_d = bit_idx_q - 3'd1;
          end else if (last_q) begin
            state_d = S_DONE;
          end else if (!accept_w) begin
            state_d = S_WAIT_BYTE;
          end
        end
        S_DONE: begin
          if (result_ack) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (accept_w) begin
        data_d    = in_data;
        last_d    = in_last;
        bit_idx_d = BIT_FIRST;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_idx_q <= BIT_FIRST;
      data_q    <= 8'h00;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      init_q    <= 1'b0;
      shift_q   <= 1'b0;
      rv_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      init_q    <= (state_d == S_INIT);
      shift_q   <= (state_d == S_SHIFT);
      rv_q      <= (state_d == S_DONE);
      busy_q    <= state_is_busy(state_d);
    end
  end

  assign in_ready       = ready_w;
  assign crc_initialize = init_q;
  assign crc_shift      = shift_q;
  assign crc_data       = data_q;
  assign crc_bit_index  = bit_idx_q;
  assign result_valid   = rv_q;
  assign busy           = busy_q;
  assign byte_count     = cnt_q;

endmodule

// File: tb/tb_crc_byte_sequencer.sv
// Drives the sequencer into a behavioural bit-serial CRC engine and compares results
// against known check values and a message-level reference CRC.
module tb_crc_byte_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, start, flush, in_valid, in_last, result_ack;
  logic [7:0]       in_data;
  logic             in_ready, crc_initialize, crc_shift, result_valid, busy;
  logic [7:0]       crc_data;
  logic [2:0]       crc_bit_index;
  logic [CNT_W-1:0] byte_count;

  crc_byte_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .crc_initialize(crc_initialize), .crc_shift(crc_shift), .crc_data(crc_data),
    .crc_bit_index(crc_bit_index), .result_valid(result_valid), .result_ack(result_ack),
    .busy(busy), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Downstream engine configuration and state
  int          cw = 8;
  logic [31:0] cpoly = 0, cinit = 0, cxor = 0;
  bit          crefin = 0, crefout = 0;
  logic [31:0] crc_reg = 0;
  int          shifts = 0;
  logic [7:0]  msg_q[$];

  function automatic logic [31:0] cmask();
    if (cw == 32) return 32'hFFFF_FFFF;
    return (32'h1 << cw) - 32'h1;
  endfunction

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    logic [31:0] n;
    logic        fb;
    fb = c[cw-1] ^ b;
    n  = (c << 1) & cmask();
    if (fb) n = n ^ (cpoly & cmask());
    return n;
  endfunction

  function automatic logic [31:0] crc_out(input logic [31:0] c);
    logic [31:0] r;
    r = c;
    if (crefout) begin
      r = 32'h0;
      for (int i = 0; i < 32; i++) if (i < cw) r[i] = c[cw-1-i];
    end
    return (r ^ cxor) & cmask();
  endfunction

  // Message-level reference: whole CRC of msg_q from the standard definition
  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = cinit;
    foreach (msg_q[k]) begin
      for (int i = 0; i < 8; i++) begin
        c = crc_bit(c, crefin ? msg_q[k][i] : msg_q[k][7-i]);
      end
    end
    return crc_out(c);
  endfunction

  always @(posedge clk) begin
    if (crc_initialize) begin
      crc_reg <= cinit;
      shifts  <= 0;
    end else if (crc_shift) begin
      crc_reg <= crc_bit(crc_reg, crefin ? crc_data[3'd7 - crc_bit_index] : crc_data[crc_bit_index]);
      shifts  <= shifts + 1;
    end
  end

  int ir_viol = 0;
  int both_viol = 0;
  always @(negedge clk) begin
    if (crc_shift && crc_bit_index != 3'd0 && in_ready) ir_viol++;
    if (crc_shift && crc_initialize) both_viol++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_crc_init", crc_initialize, 0);
    chk("rst_crc_shift", crc_shift, 0);
    chk("rst_crc_data", crc_data, 8'h00);
    chk("rst_bit_index", crc_bit_index, 3'd7);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_byte_count", byte_count, 0);
  endtask

  task automatic cfg(input int w, input logic [31:0] poly, input logic [31:0] init,
                     input bit ri, input bit ro, input logic [31:0] xo);
    cw = w; cpoly = poly; cinit = init; crefin = ri; crefout = ro; cxor = xo;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last, input int max_gap, output int acc);
    int n;
    in_valid = 1'b0;
    repeat ($urandom_range(max_gap, 0)) tick();
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("accept_timeout", in_ready, 1);
    tick();
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int rv_cyc);
    int n;
    n = 0;
    while (!result_valid && n < 200) begin
      tick();
      n++;
    end
    chk("result_timeout", result_valid, 1);
    rv_cyc = cyc;
  endtask

  task automatic run_msg(input int max_gap, output int first_acc, output int rv_cyc);
    int acc;
    pulse_start();
    first_acc = 0;
    foreach (msg_q[k]) begin
      send(msg_q[k], k == msg_q.size() - 1, max_gap, acc);
      if (k == 0) first_acc = acc;
    end
    wait_result(rv_cyc);
  endtask

  task automatic ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("ack_result_valid", result_valid, 0);
    chk("ack_busy", busy, 0);
  endtask

  task automatic load_check_string();
    msg_q.delete();
    for (int i = 0; i < 9; i++) msg_q.push_back(8'h31 + 8'(i));
  endtask

  initial begin
    int t0, tr, acc, len;
    rst = 1'b1; start = 0; flush = 0; in_valid = 0; in_data = 0; in_last = 0; result_ack = 0;
    tick();
    tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();
    check_reset_outputs();

    // CRC-8, back-to-back bytes
    cfg(8, 32'h07, 32'h0, 0, 0, 32'h0);
    load_check_string();
    run_msg(0, t0, tr);
    chk("crc8_value", crc_out(crc_reg), 32'hF4);
    chk("crc8_latency", tr - t0, 72);
    chk("crc8_byte_count", byte_count, 9);
    chk("crc8_shifts", shifts, 72);
    chk("crc8_busy_done", busy, 0);

    // Result held without ack; incoming bytes ignored
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom);
      tick();
      chk("hold_result_valid", result_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("hold_byte_count", byte_count, 9);
    chk("hold_crc_data", crc_data, 8'h39);
    chk("hold_crc", crc_out(crc_reg), 32'hF4);
    ack();

    // CRC-16/CCITT-FALSE
    cfg(16, 32'h1021, 32'hFFFF, 0, 0, 32'h0);
    run_msg(0, t0, tr);
    chk("ccitt_value", crc_out(crc_reg), 32'h29B1);
    chk("ccitt_byte_count", byte_count, 9);
    ack();

    // CRC-32 with gaps between bytes
    cfg(32, 32'h04C1_1DB7, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFF);
    run_msg(4, t0, tr);
    chk("crc32_value", crc_out(crc_reg), 32'hCBF4_3926);
    chk("crc32_byte_count", byte_count, 9);
    chk("crc32_shifts", shifts, 72);
    ack();

    // Zero-length message via flush
    cfg(16, 32'h1021, 32'hFFFF, 0, 0, 32'h0);
    pulse_start();
    chk("flush_init_pulse", crc_initialize, 1);
    tick();
    chk("flush_wait_ready", in_ready, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_result_valid", result_valid, 1);
    chk("flush_shifts", shifts, 0);
    chk("flush_crc", crc_out(crc_reg), 32'hFFFF);
    chk("flush_byte_count", byte_count, 0);
    ack();

    // Restart in the middle of a byte
    cfg(8, 32'h07, 32'h0, 0, 0, 32'h0);
    pulse_start();
    send(8'hA5, 1'b0, 0, acc);
    len = 0;
    while (crc_bit_index != 3'd4 && len < 10) begin
      tick();
      len++;
    end
    chk("mid_bit_index", crc_bit_index, 3'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_crc_init", crc_initialize, 1);
    chk("mid_crc_shift", crc_shift, 0);
    chk("mid_byte_count", byte_count, 0);
    msg_q.delete();
    msg_q.push_back(8'h00);
    send(8'h00, 1'b1, 0, acc);
    wait_result(tr);
    chk("mid_crc", crc_out(crc_reg), 32'h00);
    chk("mid_shifts", shifts, 8);
    chk("mid_byte_count_end", byte_count, 1);
    ack();

    // Reset while shifting
    pulse_start();
    send(8'h5A, 1'b0, 0, acc);
    tick();
    tick();
    chk("rst_mid_shifting", crc_shift, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs();

    // Random CRC-32 messages against the reference
    cfg(32, 32'h04C1_1DB7, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFF);
    for (int m = 0; m < 4; m++) begin
      msg_q.delete();
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      run_msg(2, t0, tr);
      chk("rand_crc", crc_out(crc_reg), ref_crc());
      chk("rand_byte_count", byte_count, len);
      chk("rand_shifts", shifts, 8 * len);
      ack();
    end

    chk("in_ready_during_bits", ir_viol, 0);
    chk("init_shift_overlap", both_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
